// File: rtl/fphub_sqrt_iter_if.sv
// Operand/result handshake bundle for the iterative HUB square root.
// The bench drives the master side; the sqrt unit sits on the slave side.
interface fphub_sqrt_iter_if #(
   parameter int M = 23,
   parameter int E = 8
);
   localparam int W = M + E + 1;

   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] res;
   logic         invalid;
   logic         done;
   logic         busy;

   modport master (
      output start, x,
      input  res, invalid, done, busy
   );

   modport slave (
      input  start, x,
      output res, invalid, done, busy
   );
endinterface

// File: rtl/fphub_sqrt_iter.sv
// Iterative square root for HUB floating point (implicit ILSB = 1), K result digits per cycle.
// Exact restoring digit recurrence; special operands bypass the iteration and finish in one cycle.
module fphub_sqrt_iter #(
   parameter int M = 23,
   parameter int E = 8,
   parameter int K = 1
) (
   input  logic              clk,
   input  logic              rst,
   fphub_sqrt_iter_if.slave  bus
);
   localparam int W    = M + E + 1;
   localparam int NW   = 2 * M + 2;                  // radicand scaled by 2^(2M)
   localparam int QW   = M + 1;                      // root including hidden one
   localparam int RW   = M + 5;                      // residual width
   localparam int NCYC = (M + K) / K;
   localparam int LAST = (M + 1) - (NCYC - 1) * K;   // digits retired in the final cycle
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   localparam logic [E:0]   BIAS = (E + 1)'((1 << (E - 1)) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NW-1:0] n_q, n_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [QW-1:0] q_q, q_d;
   logic [E-1:0]  exp_q, exp_d;
   logic          spec_q, spec_d;
   logic [W-1:0]  spec_res_q, spec_res_d;
   logic          spec_inv_q, spec_inv_d;
   logic [W-1:0]  res_q, res_d;
   logic          invalid_q, invalid_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;

   // Operand decode
   logic          op_sign;
   logic [E-1:0]  op_exp;
   logic [M-1:0]  op_man;
   logic [E:0]    exp_sum;
   logic [M+1:0]  sig_int;
   logic [NW-1:0] sig_n;

   // floor((e - bias) / 2) + bias == floor((e + bias) / 2); bit 0 gives the exponent parity.
   assign op_sign = bus.x[W-1];
   assign op_exp  = bus.x[W-2:M];
   assign op_man  = bus.x[M-1:0];
   assign exp_sum = {1'b0, op_exp} + BIAS;
   assign sig_int = {1'b1, op_man, 1'b1};
   assign sig_n   = {sig_int, {M{1'b0}}};

   // Digit recurrence for one ITER cycle
   logic [RW-1:0] rem_t;
   logic [RW-1:0] trial;
   logic [QW-1:0] q_t;
   logic [NW-1:0] n_t;
   int            ndig;

   // NOTE: combinational temporaries use blocking '=' and get a value at the top of the block,
   // so every path assigns them and no latch is inferred.
   always_comb begin
      rem_t = rem_q;
      q_t   = q_q;
      n_t   = n_q;
      trial = '0;
      ndig  = (cnt_q == CW'(NCYC - 1)) ? LAST : K;
      for (int k = 0; k < K; k++) begin
         if (k < ndig) begin
            rem_t = {rem_t[RW-3:0], n_t[NW-1 -: 2]};
            n_t   = n_t << 2;
            trial = RW'({q_t, 2'b01});
            if (rem_t >= trial) begin
               rem_t = rem_t - trial;
               q_t   = {q_t[QW-2:0], 1'b1};
            end else begin
               q_t   = {q_t[QW-2:0], 1'b0};
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      rem_d      = rem_q;
      q_d        = q_q;
      exp_d      = exp_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      spec_inv_d = spec_inv_q;
      res_d      = res_q;
      invalid_d  = invalid_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               cnt_d      = '0;
               rem_d      = '0;
               q_d        = '0;
               exp_d      = exp_sum[E:1];
               n_d        = exp_sum[0] ? sig_n : (sig_n >> 1);
               spec_d     = 1'b1;
               spec_inv_d = 1'b0;
               spec_res_d = bus.x;
               state_d    = S_DONE;
               if (op_exp == '0) begin
                  spec_res_d = {op_sign, {(W - 1){1'b0}}};
               end else if (&op_exp) begin
                  if (op_sign || (op_man != '0)) begin
                     spec_res_d = QNAN;
                     spec_inv_d = 1'b1;
                  end
               end else if (op_sign) begin
                  spec_res_d = QNAN;
                  spec_inv_d = 1'b1;
               end else begin
                  spec_d  = 1'b0;
                  state_d = S_ITER;
               end
            end
         end

         S_ITER: begin
            rem_d = rem_t;
            q_d   = q_t;
            n_d   = n_t;
            if (cnt_q == CW'(NCYC - 1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DONE: begin
            done_d    = 1'b1;
            res_d     = spec_q ? spec_res_q : {1'b0, exp_q, q_q[M-1:0]};
            invalid_d = spec_q & spec_inv_q;
            state_d   = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // Busy covers the done cycle; a start there is accepted and keeps busy high.
      busy_d = (state_d != S_IDLE) || done_d;
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         n_q        <= '0;
         rem_q      <= '0;
         q_q        <= '0;
         exp_q      <= '0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         spec_inv_q <= 1'b0;
         res_q      <= '0;
         invalid_q  <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         rem_q      <= rem_d;
         q_q        <= q_d;
         exp_q      <= exp_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         spec_inv_q <= spec_inv_d;
         res_q      <= res_d;
         invalid_q  <= invalid_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.res     = res_q;
   assign bus.invalid = invalid_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_fphub_sqrt_iter.sv
// Self-checking bench for fphub_sqrt_iter (M=23, E=8, K=1): directed table, handshake
// corner sequences and random operands against an arithmetic square-root model.
module tb_fphub_sqrt_iter;
   localparam int M    = 23;
   localparam int E    = 8;
   localparam int K    = 1;
   localparam int NCYC = 24;
   localparam int LAT  = NCYC + 1;

   logic clk = 1'b0;
   logic rst;

   fphub_sqrt_iter_if #(.M(M), .E(E)) bus ();

   fphub_sqrt_iter #(.M(M), .E(E), .K(K)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] r;
      logic        inv;
      int          lat;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic longint isqrt(input longint n);
      longint q;
      q = longint'($sqrt(real'(n)));
      while (q * q > n) q--;
      while ((q + 1) * (q + 1) <= n) q++;
      return q;
   endfunction

   // Reference: classify, then Q = floor(sqrt(R) * 2^M) using integer arithmetic on R * 2^(2M).
   function automatic void ref_sqrt(input logic [31:0] x, output logic [31:0] r,
                                    output logic inv, output logic special);
      int     s, e, eu, rexp;
      longint f, sint, n, q;
      s       = int'(x[31]);
      e       = int'(x[30:23]);
      f       = longint'(x[22:0]);
      inv     = 1'b0;
      special = 1'b1;
      r       = '0;
      if (e == 0) begin
         r = {x[31], 31'b0};
      end else if (e == 255 && f == 0 && s == 0) begin
         r = 32'h7F80_0000;
      end else if (e == 255 || s == 1) begin
         r   = 32'h7FC0_0000;
         inv = 1'b1;
      end else begin
         special = 1'b0;
         eu      = e - 127;
         sint    = (longint'(1) << (M + 1)) + (f << 1) + 1;   // S * 2^(M+1)
         n       = sint << (M - 1);                            // S * 2^(2M)
         if (eu % 2 != 0) n = n * 2;
         q       = isqrt(n);
         rexp    = (eu - ((eu % 2 + 2) % 2)) / 2 + 127;
         r       = {1'b0, rexp[7:0], q[22:0]};
      end
   endfunction

   // One operation: start, wait for done, then confirm the pulse ends and the result holds.
   task automatic run_check(input string name, input logic [31:0] xin, input logic [31:0] exp_r,
                            input logic exp_inv, input int exp_lat);
      int lat;
      int busy_bad;
      logic [31:0] r;
      logic inv;
      lat      = -1;
      busy_bad = 0;
      bus.start = 1'b1;
      bus.x     = xin;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x     = $urandom;
      for (int c = 1; c <= 200 && lat < 0; c++) begin
         if (bus.busy !== 1'b1) busy_bad++;
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) lat = c;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      r   = bus.res;
      inv = bus.invalid;
      check({name, ".lat"}, 64'(lat), 64'(exp_lat));
      check({name, ".res"}, 64'(r), 64'(exp_r));
      check({name, ".inv"}, 64'(inv), 64'(exp_inv));
      check({name, ".busy"}, 64'(busy_bad), 64'd0);
      @(posedge clk);
      #1;
      check({name, ".hold"}, {28'd0, bus.done, bus.busy, bus.invalid, 1'b0, bus.res},
                             {28'd0, 1'b0, 1'b0, exp_inv, 1'b0, exp_r});
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] xr, rr;
      logic        ir, sr;
      int          ndone, first_c, busy_bad;
      int          done_at[3];
      logic [31:0] first_res;

      tbl[0]  = '{32'h4080_0000, 32'h4000_0000, 1'b0, LAT};   // 4.0
      tbl[1]  = '{32'h4000_0000, 32'h3FB5_04F3, 1'b0, LAT};   // 2.0, odd exponent
      tbl[2]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, LAT};   // 1.0
      tbl[3]  = '{32'h3E80_0000, 32'h3F00_0000, 1'b0, LAT};   // 0.25, negative even
      tbl[4]  = '{32'h3F00_0000, 32'h3F35_04F3, 1'b0, LAT};   // 0.5, negative odd
      tbl[5]  = '{32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0, LAT};   // largest normal
      tbl[6]  = '{32'h0080_0000, 32'h2000_0000, 1'b0, LAT};   // smallest normal
      tbl[7]  = '{32'hC080_0000, 32'h7FC0_0000, 1'b1, 1};     // negative normal
      tbl[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1};     // -0
      tbl[9]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0, 1};     // +inf
      tbl[10] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1};     // +0
      tbl[11] = '{32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1};     // -inf

      // Reset, with start asserted alongside it
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.x     = 32'h4080_0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset.outputs", {bus.res, bus.invalid, bus.done, bus.busy}, '0);
      bus.start = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      #1;
      check("reset.idle", {bus.done, bus.busy}, '0);

      for (int i = 0; i < 12; i++)
         run_check($sformatf("tbl%0d", i), tbl[i].x, tbl[i].r, tbl[i].inv, tbl[i].lat);

      // NaN operand
      run_check("nan_in", 32'h7FC0_0001, 32'h7FC0_0000, 1'b1, 1);

      // Second start at cycle 10 must be ignored
      bus.start = 1'b1;
      bus.x     = 32'h4080_0000;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x     = '0;
      repeat (9) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.x     = 32'h3F80_0000;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      ndone     = 0;
      first_c   = -1;
      first_res = '0;
      for (int c = 11; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            ndone++;
            if (first_c < 0) begin
               first_c   = c;
               first_res = bus.res;
            end
         end
      end
      check("restart.ndone", 64'(ndone), 64'd1);
      check("restart.lat", 64'(first_c), 64'(LAT));
      check("restart.res", 64'(first_res), 64'h4000_0000);

      // Reset at cycle 12 aborts the operation
      bus.start = 1'b1;
      bus.x     = 32'h4000_0000;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort.outputs", {bus.res, bus.invalid, bus.done, bus.busy}, '0);
      ndone = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) ndone++;
      end
      check("abort.ndone", 64'(ndone), 64'd0);
      run_check("after_abort", 32'h4000_0000, 32'h3FB5_04F3, 1'b0, LAT);

      // Start held high: DONE-cycle start ignored, done-cycle start accepted
      bus.start = 1'b1;
      bus.x     = 32'h4080_0000;
      @(posedge clk);
      #1;
      ndone    = 0;
      busy_bad = 0;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk);
         #1;
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.done === 1'b1) begin
            if (ndone < 3) done_at[ndone] = c;
            ndone++;
         end
      end
      bus.start = 1'b0;
      check("b2b.ndone", 64'(ndone), 64'd3);
      check("b2b.done0", 64'(done_at[0]), 64'(LAT));
      check("b2b.done1", 64'(done_at[1]), 64'(LAT + NCYC + 2));
      check("b2b.done2", 64'(done_at[2]), 64'(LAT + 2 * (NCYC + 2)));
      check("b2b.busy", 64'(busy_bad), 64'd0);
      repeat (30) @(posedge clk);
      #1;

      // Random operands, mostly positive normals
      for (int i = 0; i < 300; i++) begin
         xr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            xr[31] = 1'b0;
            if (xr[30:23] == 8'd0 || xr[30:23] == 8'd255) xr[30:23] = 8'($urandom_range(1, 254));
         end
         ref_sqrt(xr, rr, ir, sr);
         run_check($sformatf("rand%0d", i), xr, rr, ir, sr ? 1 : LAT);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
